// File: rtl/fifo.sv
// Single-clock synchronous FIFO: circular buffer with read/write pointers.
// A wrap flag per pointer tells a full buffer from an empty one when the pointers are equal.
module fifo #(
    parameter int size     = 8,
    parameter int DEPTH    = 16,
    parameter int ptr_size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] wr_data,
    output logic [size-1:0] r_data,
    output logic            empty,
    output logic            full,
    input  logic            wr_en,
    input  logic            r_en
);
    localparam logic [ptr_size-1:0] LAST = ptr_size'(DEPTH - 1);

    logic [size-1:0]     mem [DEPTH];
    logic [ptr_size-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_size-1:0] r_ptr_q, r_ptr_d;
    logic                wr_flg_q, wr_flg_d;
    logic                r_flg_q, r_flg_d;
    logic [size-1:0]     r_data_q, r_data_d;
    logic                wr_acc, r_acc;

    assign empty  = (wr_ptr_q == r_ptr_q) && (wr_flg_q == r_flg_q);
    assign full   = (wr_ptr_q == r_ptr_q) && (wr_flg_q != r_flg_q);
    assign r_data = r_data_q;

    // Acceptance uses the pre-edge flags, so an empty FIFO never bypasses write data to the read side.
    assign wr_acc = wr_en && !full;
    assign r_acc  = r_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_flg_d = wr_flg_q;
        r_ptr_d  = r_ptr_q;
        r_flg_d  = r_flg_q;
        r_data_d = r_data_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            wr_flg_d = (wr_ptr_q == LAST) ? ~wr_flg_q : wr_flg_q;
        end
        if (r_acc) begin
            r_data_d = mem[r_ptr_q];
            r_ptr_d  = (r_ptr_q == LAST) ? '0 : r_ptr_q + 1'b1;
            r_flg_d  = (r_ptr_q == LAST) ? ~r_flg_q : r_flg_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            wr_flg_q <= 1'b0;
            r_ptr_q  <= '0;
            r_flg_q  <= 1'b0;
            r_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wr_flg_q <= wr_flg_d;
            r_ptr_q  <= r_ptr_d;
            r_flg_q  <= r_flg_d;
            r_data_q <= r_data_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
    end
endmodule

// File: tb/tb_fifo.sv
// Random and directed stimulus for fifo, checked against a queue-based reference model.
module tb_fifo;
    localparam int SIZE  = 8;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [SIZE-1:0] wr_data = '0;
    logic [SIZE-1:0] r_data;
    logic            empty, full;
    logic            wr_en = 1'b0;
    logic            r_en = 1'b0;

    int nvec = 0;
    int nerr = 0;

    logic [SIZE-1:0] q[$];
    logic [SIZE-1:0] exp_r = '0;

    fifo #(.size(SIZE), .DEPTH(DEPTH), .ptr_size(4)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .r_data(r_data),
        .empty(empty), .full(full), .wr_en(wr_en), .r_en(r_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".r_data"}, 32'(r_data), 32'(exp_r));
        chk({tag, ".excl"}, 32'(empty && full), 32'd0);
    endtask

    // Called at a negedge: drive, let one posedge pass, update model, check at next negedge.
    task automatic cycle(input logic we, input logic re, input logic [SIZE-1:0] wd, input string tag);
        bit pre_full, pre_empty;
        wr_en   = we;
        r_en    = re;
        wr_data = wd;
        @(posedge clk);
        pre_full  = (q.size() == DEPTH);
        pre_empty = (q.size() == 0);
        if (re && !pre_empty) exp_r = q.pop_front();
        if (we && !pre_full) q.push_back(wd);
        @(negedge clk);
        wr_en = 1'b0;
        r_en  = 1'b0;
        check_outs(tag);
    endtask

    initial begin
        logic [SIZE-1:0] w[4];
        int wp;

        // Reset state, before any clock edge
        #2;
        check_outs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Write 4 random words, then read them back
        for (int i = 0; i < 4; i++) begin
            w[i] = SIZE'($urandom);
            cycle(1'b1, 1'b0, w[i], "t2wr");
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, '0, "t2rd");
            chk("t2order", 32'(r_data), 32'(w[i]));
        end

        // Write 3 / read 3 from pointer offset 4
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, SIZE'($urandom), "t3wr");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, "t3rd");
        chk("t3wptr", 32'(dut.wr_ptr_q), 32'd7);
        chk("t3rptr", 32'(dut.r_ptr_q), 32'd7);

        // Fill to full, overflow attempt, drain
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, SIZE'(i), "t4wr");
        chk("t4full", 32'(full), 32'd1);
        cycle(1'b1, 1'b0, 8'hAA, "t4ovf");
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, '0, "t4rd");
            chk("t4order", 32'(r_data), 32'(i));
        end
        chk("t4empty", 32'(empty), 32'd1);

        // Stream 0x10..0x2F through the buffer, wrapping the pointers twice
        wp = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(wp < 32, i >= 5, SIZE'(8'h10 + wp), "t5");
            if (wp < 32) wp++;
        end

        // Underflow, then simultaneous read/write at occupancy 5
        cycle(1'b0, 1'b1, '0, "t6unf");
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, SIZE'(8'h50 + i), "t6wr");
        cycle(1'b1, 1'b1, 8'h77, "t6rw");
        chk("t6oldest", 32'(r_data), 32'h50);
        chk("t6occ", 32'(q.size()), 32'd5);

        // Asynchronous reset mid-stream
        #2 rst = 1'b0;
        q.delete();
        exp_r = '0;
        #1 check_outs("t6rst");
        @(negedge clk);
        rst = 1'b1;

        // Random traffic with shifting write/read bias to visit full and empty often
        for (int i = 0; i < 600; i++) begin
            int wb;
            wb = ((i / 100) % 2 == 0) ? 70 : 30;
            cycle($urandom_range(99) < wb, $urandom_range(99) < (100 - wb),
                  SIZE'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
